// File: rtl/module_disp_mux.sv
// module_disp_mux -- time-multiplexed N-digit hex display driver.
//
// This module captures a packed hex value once per frame. It then scans the
// digits one at a time over shared segment lines. Each digit slot begins with
// a short blanking interval so that the previous digit does not ghost onto
// the next anode.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   en_i     scan enable; 0 returns to IDLE and darkens the display
//   value_i  packed hex digits, digit k = value_i[4k+3:4k], digit 0 rightmost
//   dp_i     decimal point request per digit
//   seg_o    segments {a,b,c,d,e,f,g} at pin polarity (registered)
//   dp_o     decimal point at pin polarity (registered)
//   an_o     one-hot digit select at pin polarity (registered)
//   frame_o  one-cycle pulse in the cycle a new snapshot is held
//
// Optional build macro:
//   DISP_LZ_BLANK_EN  leading-zero suppression. A digit goes dark when it and
//                     every higher digit are zero. Digit 0 is never
//                     suppressed. A set decimal point keeps its own digit lit,
//                     and every lower digit as well.
//
// State table:
//   state | meaning
//   IDLE  | display dark, waiting for en_i
//   SCAN  | cycling digit slots; snapshot reloaded at every frame boundary

module module_disp_mux #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 27000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_o
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    // One extra bit, so that a guard length equal to the slot length can
    // still be represented.
    localparam logic [CW:0]   BLANK_W  = (CW+1)'(BLANK_CYCLES);

    localparam logic [6:0]          SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] AN_POL  = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [0:0]            state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] snapshot;
    logic [N_DIGITS-1:0]   dp_snap;

    logic [N_DIGITS-1:0]   sup;
    logic [N_DIGITS-1:0]   an_lvl;
    logic [6:0]            seg_lvl;
    logic                  dp_lvl;
    logic [3:0]            dig;
    logic                  sup_cur;
    logic                  show;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            snapshot <= '0;
            dp_snap  <= '0;
            frame_o  <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (state == IDLE) begin
                if (en_i) begin
                    state    <= SCAN;
                    cnt      <= '0;
                    idx      <= '0;
                    snapshot <= value_i;
                    dp_snap  <= dp_i;
                    frame_o  <= 1'b1;
                end
            end else begin
                if (!en_i) begin
                    state <= IDLE;
                    cnt   <= '0;
                    idx   <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    if (idx == IDX_LAST) begin
                        idx      <= '0;
                        snapshot <= value_i;
                        dp_snap  <= dp_i;
                        frame_o  <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Suppression is decided from the most significant digit downward.
    // Once a nonzero digit or a decimal point is seen, every lower digit is kept.
`ifdef DISP_LZ_BLANK_EN
    always_comb begin
        logic keep;
        keep = 1'b0;
        sup  = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            keep   = keep | (snapshot[4*k +: 4] != 4'h0) | dp_snap[k] | (k == 0);
            sup[k] = ~keep;
        end
    end
`else
    always_comb begin
        sup = '0;
    end
`endif

    always_comb begin
        show    = (state == SCAN) && ({1'b0, cnt} >= BLANK_W);
        an_lvl  = '0;
        dig     = 4'h0;
        dp_lvl  = 1'b0;
        sup_cur = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                an_lvl[k] = 1'b1;
                dig       = snapshot[4*k +: 4];
                dp_lvl    = dp_snap[k];
                sup_cur   = sup[k];
            end
        end
        seg_lvl = sup_cur ? 7'b0000000 : hex7(dig);
        if (!show) begin
            an_lvl  = '0;
            seg_lvl = 7'b0000000;
            dp_lvl  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_o <= SEG_POL;
            dp_o  <= SEG_ACTIVE_LOW;
            an_o  <= AN_POL;
        end else begin
            seg_o <= seg_lvl ^ SEG_POL;
            dp_o  <= dp_lvl ^ SEG_ACTIVE_LOW;
            an_o  <= an_lvl ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_module_disp_mux.sv
module tb_module_disp_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;

    logic [6:0]  seg0;
    logic        dp0;
    logic [3:0]  an0;
    logic        frame0;
    logic [6:0]  seg1;
    logic        dp1;
    logic [0:0]  an1;
    logic        frame1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    module_disp_mux #(
        .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .en_i(en), .value_i(value), .dp_i(dp),
        .seg_o(seg0), .dp_o(dp0), .an_o(an0), .frame_o(frame0)
    );

    module_disp_mux #(
        .N_DIGITS(1), .REFRESH_DIV(3), .BLANK_CYCLES(0),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .en_i(en), .value_i(value[3:0]), .dp_i(dp[0:0]),
        .seg_o(seg1), .dp_o(dp1), .an_o(an1), .frame_o(frame1)
    );

    function automatic int p_nd(input int i);  return (i == 0) ? 4 : 1; endfunction
    function automatic int p_rd(input int i);  return (i == 0) ? 4 : 3; endfunction
    function automatic int p_bc(input int i);  return (i == 0) ? 1 : 0; endfunction
    function automatic bit p_sal(input int i); return (i == 0); endfunction
    function automatic bit p_aal(input int i); return (i == 0); endfunction

    function automatic logic [6:0] seg_of(input int h);
        case (h)
            0: return 7'b1111110;   1: return 7'b0110000;
            2: return 7'b1101101;   3: return 7'b1111001;
            4: return 7'b0110011;   5: return 7'b1011011;
            6: return 7'b1011111;   7: return 7'b1110000;
            8: return 7'b1111111;   9: return 7'b1111011;
            10: return 7'b1110111;  11: return 7'b0011111;
            12: return 7'b1001110;  13: return 7'b0111101;
            14: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Reference model: while running, t counts cycles since the frame began.
    // The slot, the position in the slot and the frame boundary all come from t.
    bit          m_run [2];
    int          m_t   [2];
    logic [31:0] m_snap[2];
    logic [7:0]  m_dps [2];
    logic [6:0]  exp_seg  [2];
    logic        exp_dp   [2];
    logic [7:0]  exp_an   [2];
    logic        exp_frame[2];

    task automatic model_outputs(input int i);
        logic [6:0] s;
        logic [7:0] a;
        logic [7:0] mask;
        logic       d;
        int         dg;
        int         h;
        s = '0; a = '0; d = 1'b0;
        mask = 8'((1 << p_nd(i)) - 1);
        if (m_run[i] && (m_t[i] % p_rd(i)) >= p_bc(i)) begin
            dg = (m_t[i] / p_rd(i)) % p_nd(i);
            h  = int'((m_snap[i] >> (4 * dg)) & 32'hF);
            a  = 8'(1 << dg);
            s  = seg_of(h);
            d  = m_dps[i][dg];
`ifdef DISP_LZ_BLANK_EN
            if (dg != 0 && (m_snap[i] >> (4 * dg)) == 0 && (m_dps[i] >> dg) == 0)
                s = '0;
`endif
        end
        exp_seg[i] = p_sal(i) ? ~s : s;
        exp_dp[i]  = p_sal(i) ? ~d : d;
        exp_an[i]  = p_aal(i) ? (~a & mask) : a;
    endtask

    task automatic model_step(input int i);
        logic [31:0] vm;
        logic [7:0]  dm;
        vm = (i == 0) ? {16'h0, value} : {28'h0, value[3:0]};
        dm = (i == 0) ? {4'h0, dp} : {7'h0, dp[0]};
        exp_frame[i] = 1'b0;
        if (!m_run[i]) begin
            if (en) begin
                m_run[i] = 1'b1; m_t[i] = 0; m_snap[i] = vm; m_dps[i] = dm;
                exp_frame[i] = 1'b1;
            end
        end else if (!en) begin
            m_run[i] = 1'b0; m_t[i] = 0;
        end else begin
            m_t[i] = (m_t[i] + 1) % (p_rd(i) * p_nd(i));
            if (m_t[i] == 0) begin
                m_snap[i] = vm; m_dps[i] = dm; exp_frame[i] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] = 1'b0; m_t[i] = 0; m_snap[i] = '0; m_dps[i] = '0;
                exp_frame[i] = 1'b0;
                model_outputs(i);
            end else begin
                model_outputs(i);
                model_step(i);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m0_an",    32'(an0),    32'(exp_an[0][3:0]));
            check("m0_seg",   32'(seg0),   32'(exp_seg[0]));
            check("m0_dp",    32'(dp0),    32'(exp_dp[0]));
            check("m0_frame", 32'(frame0), 32'(exp_frame[0]));
            check("m1_an",    32'(an1),    32'(exp_an[1][0]));
            check("m1_seg",   32'(seg1),   32'(exp_seg[1]));
            check("m1_dp",    32'(dp1),    32'(exp_dp[1]));
            check("m1_frame", 32'(frame1), 32'(exp_frame[1]));
        end
    end

    task automatic wait_frame(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (frame0) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL wait_frame at %0t: got no frame pulse expected one within %0d cycles", $time, budget);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; value = 16'h3A5F; dp = 4'b0100;
        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_an",    32'(an0),    32'h0F);
        check("rst_seg",   32'(seg0),   32'h7F);
        check("rst_dp",    32'(dp0),    32'h1);
        check("rst_frame", 32'(frame0), 32'h0);
        @(posedge clk); #2 rst = 1'b0;

        wait_frame(20);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            case (c)
                2:  begin check("s_an0", 32'(an0), 32'hE); check("s_seg0", 32'(seg0), 32'h38);
                          check("s_dp0", 32'(dp0), 32'h1); end
                5:  check("s_blank", 32'(an0), 32'hF);
                6:  begin check("s_an1", 32'(an0), 32'hD); check("s_seg1", 32'(seg0), 32'h24);
                          check("s_dp1", 32'(dp0), 32'h1); value = 16'h0000; end
                10: begin check("s_an2", 32'(an0), 32'hB); check("s_seg2", 32'(seg0), 32'h08);
                          check("s_dp2", 32'(dp0), 32'h0); end
                14: begin check("s_an3", 32'(an0), 32'h7); check("s_seg3", 32'(seg0), 32'h06); end
                16: check("s_frame2", 32'(frame0), 32'h1);
                18: begin check("s_new_an0", 32'(an0), 32'hE); check("s_new_seg0", 32'(seg0), 32'h01); end
                19: en = 1'b0;
                default: ;
            endcase
        end
        repeat (2) @(negedge clk);
        check("dis_an",  32'(an0),  32'hF);
        check("dis_seg", 32'(seg0), 32'h7F);
        value = 16'h1234; dp = 4'b0000; en = 1'b1;
        wait_frame(5);
        repeat (2) @(negedge clk);
        check("re_an0",  32'(an0),  32'hE);
        check("re_seg0", 32'(seg0), 32'h4C);

        en = 1'b0;
        repeat (2) @(negedge clk);
        value = 16'h0070; dp = 4'b0000; en = 1'b1;
        wait_frame(5);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            case (c)
                2:  begin check("lz_an0", 32'(an0), 32'hE); check("lz_seg0", 32'(seg0), 32'h01); end
                6:  begin check("lz_an1", 32'(an0), 32'hD); check("lz_seg1", 32'(seg0), 32'h0F); end
                10: begin check("lz_an2", 32'(an0), 32'hB);
`ifdef DISP_LZ_BLANK_EN
                          check("lz_seg2", 32'(seg0), 32'h7F);
`else
                          check("lz_seg2", 32'(seg0), 32'h01);
`endif
                    end
                14: begin check("lz_an3", 32'(an0), 32'h7);
`ifdef DISP_LZ_BLANK_EN
                          check("lz_seg3", 32'(seg0), 32'h7F);
`else
                          check("lz_seg3", 32'(seg0), 32'h01);
`endif
                          dp = 4'b1000;
                    end
                default: ;
            endcase
        end
        wait_frame(5);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 10) check("lzdp_seg2", 32'(seg0), 32'h01);
            if (c == 14) begin
                check("lzdp_seg3", 32'(seg0), 32'h01);
                check("lzdp_dp3",  32'(dp0),  32'h0);
            end
        end

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            if (rst) begin
                if ($urandom_range(0, 1) == 1) rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) value = 16'($urandom);
            if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
            if (en) begin
                if ($urandom_range(0, 149) == 0) en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                en = 1'b1;
            end
        end
        @(posedge clk); #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
